run_halt_dump: RTL and testbench
================================

Name: run_halt_dump

Overview:
- Sits downstream of the 64-bit sequential CPU core.
- Counts executed cycles and watches the core's PC for the end-of-program condition.
- On halt, freezes the core and walks the register file's read port, emitting all 32 registers and then the cycle count as a valid/ready word stream.
- Replaces ad-hoc end-of-run logic with a synthesizable, reusable dump engine feeding a file writer, UART or scoreboard.

Parameters:
- XLEN, 64, register/PC/data width.
- END_PC, 60, halt when pc_in >= END_PC (unsigned compare).
- CNT_W, 32, cycle counter width; zero-extended to XLEN on output.
- STALL_LIMIT, 4, consecutive unchanged-PC cycles that trigger halt (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; also holds the CPU in reset.
- pc_in  in  XLEN  current CPU program counter.
- cpu_halt  out  1  1 = CPU clock-enable deasserted (core frozen).
- rf_rd_addr  out  5  register-file read address driven during dump.
- rf_rd_data  in  XLEN  combinational read data for rf_rd_addr (x0 reads 0).
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts word when valid&ready at rising edge.
- dump_data  out  XLEN  register value or zero-extended cycle count.
- dump_last  out  1  marks final word (cycle count).
- cycle_count  out  CNT_W  live cycle counter.
- done  out  1  sticky dump-complete flag.

Behaviour:
- FSM states: RUN, DUMP_REG, DUMP_CNT, DONE.
- Reset (any state, any cycle, including mid-dump) sets:
  - state=RUN, cycle_count=0, idx=0.
  - cpu_halt=0, dump_valid=0, dump_last=0, done=0.
  - rf_rd_addr=0, dump_data=0, stall counter=0, prev_pc=0.
- RUN:
  - cycle_count increments every non-reset cycle, saturating at all-ones.
  - If pc_in >= END_PC: the increment still applies that cycle; next state DUMP_REG, idx=0, cpu_halt=1 from the next cycle.
- DUMP_REG:
  - rf_rd_addr=idx, dump_data=rf_rd_data (combinational), dump_valid=1, dump_last=0.
  - On handshake: if idx==31 go DUMP_CNT, else idx+1.
  - Without ready, addr/data are held; data stays stable because the core is frozen.
  - Exactly one word per handshake; back-to-back handshakes allowed (32 cycles minimum).
- DUMP_CNT:
  - dump_data={zeros, cycle_count}, dump_valid=1, dump_last=1.
  - On handshake go DONE.
- DONE: dump_valid=0, done=1, cpu_halt=1, cycle_count frozen; held until reset.
- cycle_count does not increment outside RUN.
- cpu_halt=1 in all states except RUN.
- dump_ready is ignored when dump_valid=0.
- Halt detection only in RUN; pc_in changes after halt are ignored.
- Latency: halt-detect edge to first dump_valid = 1 cycle.
- Minimum total dump time: 33 cycles with ready tied high.

Optional Feature:
- Macro: RUN_HALT_DUMP_STALL_DETECT_EN.
- Defined:
  - In RUN, prev_pc is registered each cycle.
  - If pc_in==prev_pc, a stall counter increments; otherwise it clears.
  - When the counter reaches STALL_LIMIT, halt identically to the END_PC condition, whichever fires first.
  - This catches self-loop "j ." program terminations.
- Not defined: no prev_pc/stall logic; halt only on pc_in >= END_PC.

Test Plan:
- Reset, pc_in steps 0,4,…,60 one per cycle, dump_ready=1 → cpu_halt rises the cycle after pc_in=60; cycle_count=16; 33 words stream back-to-back; last word=16 with dump_last=1; done=1.
- Preload rf model regs[i]=0x1111_0000_0000_0000+i, regs[0]=0 → words 0..31 match in order; rf_rd_addr sequence 0..31.
- dump_ready toggled 1-of-3 cycles → dump_data/rf_rd_addr held while valid&!ready; still exactly 33 accepted words, no duplicates or skips.
- Assert reset during DUMP_REG at idx=10 → next cycle state RUN, cycle_count=0, dump_valid=0, cpu_halt=0; new run dumps from idx 0.
- With STALL_DETECT_EN, STALL_LIMIT=4, pc_in held at 0x20 from cycle 8 → halt after 4 equal-PC cycles, dump starts; without macro, no halt until pc_in >= 60.
- After done=1, pulse dump_ready and change pc_in → no further dump_valid; cycle_count frozen.

Source files
------------

// File: rtl/run_halt_dump_if.sv
// run_halt_dump_if: CPU-side and dump-stream signals of the run/halt/dump engine.
// master = the dump engine, slave = the core/consumer environment around it.
interface run_halt_dump_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
);
   logic [XLEN-1:0]  pc_in;
   logic             cpu_halt;
   logic [4:0]       rf_rd_addr;
   logic [XLEN-1:0]  rf_rd_data;
   logic             dump_valid;
   logic             dump_ready;
   logic [XLEN-1:0]  dump_data;
   logic             dump_last;
   logic [CNT_W-1:0] cycle_count;
   logic             done;

   modport master (
      input  pc_in, rf_rd_data, dump_ready,
      output cpu_halt, rf_rd_addr, dump_valid, dump_data, dump_last, cycle_count, done
   );

   modport slave (
      output pc_in, rf_rd_data, dump_ready,
      input  cpu_halt, rf_rd_addr, dump_valid, dump_data, dump_last, cycle_count, done
   );
endinterface

// File: rtl/run_halt_dump.sv
// run_halt_dump: counts core cycles, detects end of program (pc_in >= END_PC),
// then freezes the core and streams x0..x31 followed by the cycle count.
// Optional macro RUN_HALT_DUMP_STALL_DETECT_EN adds halt on STALL_LIMIT
// consecutive unchanged-PC cycles (catches "j ." self-loops).
module run_halt_dump #(
   parameter int XLEN   = 64,
   parameter int END_PC = 60,
   parameter int CNT_W  = 32
`ifdef RUN_HALT_DUMP_STALL_DETECT_EN
   , parameter int STALL_LIMIT = 4
`endif
) (
   input  logic              clk,
   input  logic              reset,
   run_halt_dump_if.master   bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DUMP_REG = 2'd1,
      DUMP_CNT = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [XLEN-1:0]  END_PC_V = XLEN'(END_PC);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t            state_r, state_s;
   logic [4:0]        idx_r, idx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              halt_hit_s;
   logic              stall_hit_s;

`ifdef RUN_HALT_DUMP_STALL_DETECT_EN
   localparam int             STALL_W   = $clog2(STALL_LIMIT + 1) + 1;
   localparam logic [STALL_W-1:0] STALL_LIM_V = STALL_W'(STALL_LIMIT);
   localparam logic [STALL_W-1:0] STALL_ONE   = {{(STALL_W-1){1'b0}}, 1'b1};
   logic [XLEN-1:0]    prev_pc_r, prev_pc_s;
   logic [STALL_W-1:0] stall_r, stall_s;
   logic               pc_same_s;

   // Stall tracker: count consecutive cycles where the PC did not move
   always_comb begin
      pc_same_s   = (bus.pc_in == prev_pc_r);
      prev_pc_s   = prev_pc_r;
      stall_s     = stall_r;
      stall_hit_s = 1'b0;
      if (state_r == RUN) begin
         prev_pc_s = bus.pc_in;
         if (pc_same_s) begin
            stall_s     = (stall_r >= STALL_LIM_V) ? stall_r : (stall_r + STALL_ONE);
            stall_hit_s = ((stall_r + STALL_ONE) >= STALL_LIM_V);
         end else begin
            stall_s     = {STALL_W{1'b0}};
         end
      end else begin
         prev_pc_s = prev_pc_r;
      end
   end

   // Stall tracker registers
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_pc_r <= {XLEN{1'b0}};
         stall_r   <= {STALL_W{1'b0}};
      end else begin
         prev_pc_r <= prev_pc_s;
         stall_r   <= stall_s;
      end
   end
`else
   assign stall_hit_s = 1'b0;
`endif

   assign halt_hit_s = (bus.pc_in >= END_PC_V) || stall_hit_s;

   // State register with dump index and saturating cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RUN;
         idx_r   <= 5'd0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic: halt detection, one word advanced per handshake
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      case (state_r)
         RUN: begin
            cnt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
            if (halt_hit_s) begin
               state_s = DUMP_REG;
               idx_s   = 5'd0;
            end else begin
               state_s = RUN;
            end
         end
         DUMP_REG: begin
            if (bus.dump_ready) begin
               if (idx_r == 5'd31) begin
                  state_s = DUMP_CNT;
               end else begin
                  idx_s = idx_r + 5'd1;
               end
            end else begin
               idx_s = idx_r;
            end
         end
         DUMP_CNT: begin
            if (bus.dump_ready) begin
               state_s = DONE;
            end else begin
               state_s = DUMP_CNT;
            end
         end
         DONE: begin
            state_s = DONE;
         end
         default: begin
            state_s = RUN;
         end
      endcase
   end

   // Output decode; register data passes straight through from the frozen register file
   always_comb begin
      bus.cpu_halt   = 1'b1;
      bus.rf_rd_addr = 5'd0;
      bus.dump_valid = 1'b0;
      bus.dump_data  = {XLEN{1'b0}};
      bus.dump_last  = 1'b0;
      bus.done       = 1'b0;
      case (state_r)
         RUN: begin
            bus.cpu_halt = 1'b0;
         end
         DUMP_REG: begin
            bus.rf_rd_addr = idx_r;
            bus.dump_data  = bus.rf_rd_data;
            bus.dump_valid = 1'b1;
         end
         DUMP_CNT: begin
            bus.dump_data  = {{(XLEN-CNT_W){1'b0}}, cnt_r};
            bus.dump_valid = 1'b1;
            bus.dump_last  = 1'b1;
         end
         DONE: begin
            bus.done = 1'b1;
         end
         default: begin
            bus.cpu_halt = 1'b1;
         end
      endcase
   end

   assign bus.cycle_count = cnt_r;

endmodule

// File: tb/tb_run_halt_dump.sv
// Directed bench for run_halt_dump: reset, full dump, throttled ready,
// reset mid-dump, stall behaviour and post-done quiescence.
module tb_run_halt_dump;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [63:0] regs [32];

   run_halt_dump_if #(.XLEN(64), .CNT_W(32)) bus ();

   run_halt_dump dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.rf_rd_data = regs[bus.rf_rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] exp_word(input int w);
      if (w == 0)       return 64'd0;
      else if (w < 32)  return 64'h1111_0000_0000_0000 + 64'(w);
      else              return 64'd16;
   endfunction

   // stimulus only: reset then step pc 0,4,..,60; leaves DUT just entered DUMP_REG
   task automatic run_to_halt();
      reset = 1'b1; bus.pc_in = 64'd0; bus.dump_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         bus.pc_in = 64'(4 * k);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.pc_in = 64'd0; bus.dump_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      total++; if (bus.cpu_halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", bus.cpu_halt); end
      total++; if (bus.dump_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.dump_valid); end
      total++; if (bus.dump_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", bus.dump_last); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      total++; if (bus.cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.cycle_count); end
      total++; if (bus.rf_rd_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.rf_rd_addr); end
      total++; if (bus.dump_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.dump_data); end
   endtask

   task automatic test_run_dump();
      int w; int cyc;
      reset = 1'b1; bus.pc_in = 64'd0; bus.dump_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         bus.pc_in = 64'(4 * k);
         @(negedge clk);
         if (k < 15) begin
            total++; if (bus.cpu_halt !== 1'b0) begin bad++; $display("FAIL run_halt k=%0d got=%b exp=0", k, bus.cpu_halt); end
         end
         total++; if (bus.cycle_count !== 32'(k + 1)) begin bad++; $display("FAIL run_count k=%0d got=%0d exp=%0d", k, bus.cycle_count, k + 1); end
      end
      total++; if (bus.cpu_halt !== 1'b1) begin bad++; $display("FAIL halt_rise got=%b exp=1", bus.cpu_halt); end
      total++; if (bus.dump_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", bus.dump_valid); end
      w = 0; cyc = 0;
      while (w < 33 && cyc < 100) begin
         bus.pc_in = 64'h1234;
         if (bus.dump_valid !== 1'b1) begin
            total++; bad++; $display("FAIL stream_valid w=%0d got=%b exp=1", w, bus.dump_valid);
         end else begin
            total++; if (bus.dump_data !== exp_word(w)) begin bad++; $display("FAIL word w=%0d got=%h exp=%h", w, bus.dump_data, exp_word(w)); end
            total++; if (bus.dump_last !== (w == 32)) begin bad++; $display("FAIL last w=%0d got=%b exp=%b", w, bus.dump_last, (w == 32)); end
            if (w < 32) begin
               total++; if (bus.rf_rd_addr !== 5'(w)) begin bad++; $display("FAIL addr w=%0d got=%0d exp=%0d", w, bus.rf_rd_addr, w); end
            end
            w++;
         end
         @(negedge clk);
         cyc++;
      end
      total++; if (cyc !== 33) begin bad++; $display("FAIL dump_cycles got=%0d exp=33", cyc); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done got=%b exp=1", bus.done); end
      total++; if (bus.dump_valid !== 1'b0) begin bad++; $display("FAIL done_valid got=%b exp=0", bus.dump_valid); end
      total++; if (bus.cycle_count !== 32'd16) begin bad++; $display("FAIL done_count got=%0d exp=16", bus.cycle_count); end
   endtask

   task automatic test_ready_throttle();
      int w; int cyc; logic held; logic [63:0] pdata; logic [4:0] paddr;
      run_to_halt();
      w = 0; cyc = 0; held = 1'b0; pdata = 64'd0; paddr = 5'd0;
      while (w < 33 && cyc < 300) begin
         bus.dump_ready = (cyc % 3 == 0);
         if (bus.dump_valid === 1'b1) begin
            total++; if (bus.dump_data !== exp_word(w)) begin bad++; $display("FAIL thr_word w=%0d got=%h exp=%h", w, bus.dump_data, exp_word(w)); end
            if (held) begin
               total++; if (bus.dump_data !== pdata) begin bad++; $display("FAIL thr_hold_data got=%h exp=%h", bus.dump_data, pdata); end
               total++; if (bus.rf_rd_addr !== paddr) begin bad++; $display("FAIL thr_hold_addr got=%0d exp=%0d", bus.rf_rd_addr, paddr); end
            end
            held  = !bus.dump_ready;
            pdata = bus.dump_data;
            paddr = bus.rf_rd_addr;
            if (bus.dump_ready) w++;
         end else begin
            total++; bad++; $display("FAIL thr_valid w=%0d got=%b exp=1", w, bus.dump_valid);
         end
         @(negedge clk);
         cyc++;
      end
      total++; if (w !== 33) begin bad++; $display("FAIL thr_words got=%0d exp=33", w); end
      total++; if (cyc !== 97) begin bad++; $display("FAIL thr_cycles got=%0d exp=97", cyc); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL thr_done got=%b exp=1", bus.done); end
   endtask

   task automatic test_after_done();
      for (int i = 0; i < 6; i++) begin
         bus.dump_ready = i[0];
         bus.pc_in = 64'(i * 8);
         @(negedge clk);
         total++; if (bus.dump_valid !== 1'b0) begin bad++; $display("FAIL post_valid i=%0d got=%b exp=0", i, bus.dump_valid); end
         total++; if (bus.cycle_count !== 32'd16) begin bad++; $display("FAIL post_count i=%0d got=%0d exp=16", i, bus.cycle_count); end
         total++; if (bus.done !== 1'b1 || bus.cpu_halt !== 1'b1) begin bad++; $display("FAIL post_flags i=%0d got=%b%b exp=11", i, bus.done, bus.cpu_halt); end
      end
   endtask

   task automatic test_reset_mid_dump();
      int cyc;
      run_to_halt();
      bus.dump_ready = 1'b1;
      cyc = 0;
      while (bus.rf_rd_addr !== 5'd10 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      total++; if (cyc !== 10) begin bad++; $display("FAIL mid_reach got=%0d exp=10", cyc); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (bus.cycle_count !== 32'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", bus.cycle_count); end
      total++; if (bus.dump_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", bus.dump_valid); end
      total++; if (bus.cpu_halt !== 1'b0) begin bad++; $display("FAIL mid_halt got=%b exp=0", bus.cpu_halt); end
      total++; if (bus.rf_rd_addr !== 5'd0) begin bad++; $display("FAIL mid_addr got=%0d exp=0", bus.rf_rd_addr); end
      reset = 1'b0; bus.pc_in = 64'd60; bus.dump_ready = 1'b0;
      @(negedge clk);
      total++; if (bus.cycle_count !== 32'd1) begin bad++; $display("FAIL re_count got=%0d exp=1", bus.cycle_count); end
      total++; if (bus.dump_valid !== 1'b1 || bus.rf_rd_addr !== 5'd0) begin bad++; $display("FAIL re_start got=%b/%0d exp=1/0", bus.dump_valid, bus.rf_rd_addr); end
      bus.dump_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.rf_rd_addr !== 5'd1 || bus.dump_data !== exp_word(1)) begin bad++; $display("FAIL re_second got=%0d/%h exp=1/%h", bus.rf_rd_addr, bus.dump_data, exp_word(1)); end
   endtask

   task automatic test_stall();
      reset = 1'b1; bus.pc_in = 64'd0; bus.dump_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 25; k++) begin
         bus.pc_in = (k < 8) ? 64'(4 * k) : 64'h20;
         @(negedge clk);
`ifdef RUN_HALT_DUMP_STALL_DETECT_EN
         if (k == 11) begin
            total++; if (bus.cpu_halt !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", bus.cpu_halt); end
         end
         if (k == 12) begin
            total++; if (bus.cpu_halt !== 1'b1 || bus.dump_valid !== 1'b1) begin bad++; $display("FAIL stall_halt got=%b%b exp=11", bus.cpu_halt, bus.dump_valid); end
            total++; if (bus.cycle_count !== 32'd13) begin bad++; $display("FAIL stall_count got=%0d exp=13", bus.cycle_count); end
         end
`else
         if (k == 24) begin
            total++; if (bus.cpu_halt !== 1'b0) begin bad++; $display("FAIL nostall_halt got=%b exp=0", bus.cpu_halt); end
            total++; if (bus.cycle_count !== 32'd25) begin bad++; $display("FAIL nostall_count got=%0d exp=25", bus.cycle_count); end
         end
`endif
      end
`ifndef RUN_HALT_DUMP_STALL_DETECT_EN
      bus.pc_in = 64'd60;
      @(negedge clk);
      total++; if (bus.cpu_halt !== 1'b1 || bus.cycle_count !== 32'd26) begin bad++; $display("FAIL endpc_halt got=%b/%0d exp=1/26", bus.cpu_halt, bus.cycle_count); end
`endif
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; bus.pc_in = 64'd0; bus.dump_ready = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 64'd0 : 64'h1111_0000_0000_0000 + 64'(i);
      @(negedge clk);
      test_reset();
      test_run_dump();
      test_ready_throttle();
      test_after_done();
      test_reset_mid_dump();
      test_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
